// File: rtl/fisc_fetch_unit.sv
// fisc_fetch_unit: owns the PC, fetches 64-bit blocks and hands out 32-bit instructions low half first.
// Optional FISC_FETCH_PREFETCH_EN adds a one-block prefetch buffer behind the line buffer.
module fisc_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INT_W  = 64,
    parameter int INS_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_rd,
    output logic [ADDR_W-4:0] mem_addr,
    input  logic [INT_W-1:0]  mem_rdata,
    input  logic              mem_rvalid,
    output logic              inst_valid,
    output logic [INS_W-1:0]  inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              fault
);
    localparam int BLK_W = ADDR_W - 3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DELIVER} state_t;

    state_t            state_q, state_d, resume;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INT_W-1:0]  line_q, line_d;
    logic [INS_W-1:0]  inst_q, inst_d;
    logic [BLK_W-1:0]  mem_addr_q, mem_addr_d;
    logic              inst_valid_q, inst_valid_d;
    logic              mem_rd_q, mem_rd_d;
    logic              fault_q, fault_d;
    logic              drop_q, drop_d;
    logic              outst_q, outst_d;
    logic              hs, rsp, pf_issue;
`ifdef FISC_FETCH_PREFETCH_EN
    logic [INT_W-1:0]  pf_q, pf_d;
    logic              pf_v_q, pf_v_d;
    logic              pf_out_q, pf_out_d;
`endif

    function automatic logic [INS_W-1:0] half_of(input logic [INT_W-1:0] b, input logic s);
        return s ? b[INT_W-1:INS_W] : b[INS_W-1:0];
    endfunction

    always_comb begin
        hs           = inst_valid_q & inst_ready;
        rsp          = mem_rvalid & outst_q;
        resume       = enable ? S_REQ : S_IDLE;
        state_d      = state_q;
        pc_d         = pc_q;
        line_d       = line_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        drop_d       = drop_q;
        fault_d      = 1'b0;
        pf_issue     = 1'b0;
        outst_d      = (outst_q & ~mem_rvalid) | mem_rd_q;
`ifdef FISC_FETCH_PREFETCH_EN
        pf_d         = pf_q;
        pf_v_d       = pf_v_q;
        pf_out_d     = pf_out_q & ~mem_rvalid;
`endif
        case (state_q)
            S_IDLE: if (enable) state_d = S_REQ;
            S_REQ: state_d = S_WAIT;
            S_WAIT: if (rsp) begin
                if (drop_q) begin
                    drop_d  = 1'b0;
                    state_d = resume;
                end else begin
                    line_d       = mem_rdata;
                    inst_d       = half_of(mem_rdata, pc_q[2]);
                    inst_valid_d = 1'b1;
                    state_d      = S_DELIVER;
`ifdef FISC_FETCH_PREFETCH_EN
                    pf_issue     = enable;
`endif
                end
            end
            S_DELIVER: begin
`ifdef FISC_FETCH_PREFETCH_EN
                if (rsp) begin
                    pf_d   = mem_rdata;
                    pf_v_d = 1'b1;
                end
`endif
                if (hs) begin
                    pc_d = pc_q + ADDR_W'(4);
                    if (!pc_q[2]) begin
                        inst_d = half_of(line_q, 1'b1);
`ifdef FISC_FETCH_PREFETCH_EN
                    // A prefetch landing this very cycle is forwarded straight into the line buffer.
                    end else if (pf_v_q || rsp) begin
                        line_d   = pf_v_q ? pf_q : mem_rdata;
                        inst_d   = half_of(line_d, 1'b0);
                        pf_v_d   = 1'b0;
                        pf_issue = enable;
                    end else begin
                        inst_valid_d = 1'b0;
                        state_d      = pf_out_q ? S_WAIT : resume;
                    end
`else
                    end else begin
                        inst_valid_d = 1'b0;
                        state_d      = resume;
                    end
`endif
                end
            end
        endcase
        // A redirect behind an outstanding request waits for the stale response before refetching.
        if (redirect) begin
            pc_d         = {redirect_pc[ADDR_W-1:2], 2'b00};
            inst_valid_d = 1'b0;
            fault_d      = |redirect_pc[1:0];
            drop_d       = (outst_q & ~mem_rvalid) | mem_rd_q;
            state_d      = drop_d ? S_WAIT : resume;
            pf_issue     = 1'b0;
`ifdef FISC_FETCH_PREFETCH_EN
            pf_v_d       = 1'b0;
            pf_out_d     = 1'b0;
`endif
        end
`ifdef FISC_FETCH_PREFETCH_EN
        pf_out_d   = pf_out_d | pf_issue;
`endif
        mem_rd_d   = (state_d == S_REQ) | pf_issue;
        mem_addr_d = pc_d[ADDR_W-1:3] + BLK_W'(pf_issue);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            line_q       <= '0;
            inst_q       <= '0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            fault_q      <= 1'b0;
            drop_q       <= 1'b0;
            outst_q      <= 1'b0;
`ifdef FISC_FETCH_PREFETCH_EN
            pf_q         <= '0;
            pf_v_q       <= 1'b0;
            pf_out_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            line_q       <= line_d;
            inst_q       <= inst_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            mem_rd_q     <= mem_rd_d;
            fault_q      <= fault_d;
            drop_q       <= drop_d;
            outst_q      <= outst_d;
`ifdef FISC_FETCH_PREFETCH_EN
            pf_q         <= pf_d;
            pf_v_q       <= pf_v_d;
            pf_out_q     <= pf_out_d;
`endif
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = pc_q;
    assign fault      = fault_q;
endmodule

// File: tb/tb_fisc_fetch_unit.sv
// tb_fisc_fetch_unit: drives the fetch unit against a latency-programmable memory and
// checks the delivered instruction stream against a PC-sequence model.
module tb_fisc_fetch_unit;
    localparam int AW = 16;
    localparam int BW = 13;

    logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b0, redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          mem_rd, mem_rvalid = 1'b0, inst_valid, inst_ready = 1'b0, fault;
    logic [BW-1:0] mem_addr;
    logic [63:0]   mem_rdata = '0;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;

    fisc_fetch_unit #(.ADDR_W(AW), .INT_W(64), .INS_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .fault(fault)
    );

    always #5 clk = ~clk;

    int            tests = 0, fails = 0, hs_count = 0, lat = 1;
    bit            rand_lat = 1'b0, pend = 1'b0, fault_exp = 1'b0, stall_prev = 1'b0;
    int            cnt = 0;
    logic [BW-1:0] paddr = '0;
    logic [AW-1:0] exp_pc = '0, stall_pc = '0;
    logic [31:0]   stall_inst = '0;
    logic [63:0]   mem [0:(1<<BW)-1];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [15:0] p);
        return {p ^ 16'hA5C3, p};
    endfunction

    function automatic logic [31:0] exp_ins(input logic [15:0] p);
        logic [63:0] b;
        b = mem[p[15:3]];
        return p[2] ? b[63:32] : b[31:0];
    endfunction

    // Memory responder plus stream model; outputs are sampled on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[paddr];
                    pend       = 1'b0;
                end else cnt--;
            end
            @(negedge clk);
            if (!reset_n) begin
                exp_pc     = '0;
                fault_exp  = 1'b0;
                stall_prev = 1'b0;
            end else begin
                check("fault", fault, fault_exp);
                if (mem_rd) begin
                    check("one_outstanding", pend, 0);
`ifdef FISC_FETCH_PREFETCH_EN
                    check("mem_addr", 64'(mem_addr == exp_pc[15:3] || mem_addr == exp_pc[15:3] + 13'd1), 1);
`else
                    check("mem_addr", mem_addr, exp_pc[15:3]);
                    check("rd_while_valid", inst_valid, 0);
`endif
                    pend  = 1'b1;
                    cnt   = rand_lat ? int'($urandom_range(1, 4)) : lat;
                    paddr = mem_addr;
                end
                if (stall_prev) begin
                    check("stall_valid", inst_valid, 1);
                    check("stall_inst", inst, stall_inst);
                    check("stall_pc", inst_pc, stall_pc);
                end
                stall_prev = inst_valid & ~inst_ready;
                stall_inst = inst;
                stall_pc   = inst_pc;
                if (inst_valid && inst_ready) begin
                    check("inst_pc", inst_pc, exp_pc);
                    check("inst", inst, exp_ins(exp_pc));
                    exp_pc += 16'd4;
                    hs_count++;
                end
                fault_exp = redirect & (|redirect_pc[1:0]);
                if (redirect) begin
                    exp_pc     = redirect_pc & ~16'd3;
                    stall_prev = 1'b0;
                end
            end
        end
    end

    task automatic wait_rd(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = mem_rd;
        end
        check(name, seen, 1);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = inst_valid;
        end
        check(name, seen, 1);
    endtask

    task automatic wait_hs_pc(input string name, input logic [AW-1:0] target);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = inst_valid && inst_ready && inst_pc == target;
        end
        check(name, seen, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h0;
        for (int a = 0; a < (1 << BW); a++) mem[a] = {ins_of(16'(a * 8 + 4)), ins_of(16'(a * 8))};
        mem[0] = 64'h2222222211111111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_fault", fault, 0);
        step();
        reset_n = 1'b1; enable = 1'b1; inst_ready = 1'b1; lat = 1;
`ifndef FISC_FETCH_PREFETCH_EN
        wait_rd("t1_rd0_seen");
        check("t1_rd0_addr", mem_addr, 0);
        wait_valid("t1_valid_seen");
        check("t1_inst0", inst, 32'h11111111);
        check("t1_pc0", inst_pc, 0);
        @(negedge clk);
        check("t1_valid1", inst_valid, 1);
        check("t1_inst1", inst, 32'h22222222);
        check("t1_pc1", inst_pc, 4);
        wait_rd("t1_rd1_seen");
        check("t1_rd1_addr", mem_addr, 1);
        step();
        inst_ready = 1'b0;
        wait_valid("t2_valid_seen");
        check("t2_pc", inst_pc, 8);
        check("t2_inst", inst, mem[1][31:0]);
        repeat (5) @(negedge clk);
        check("t2_pc_hold", inst_pc, 8);
        check("t2_inst_hold", inst, mem[1][31:0]);
        step();
        inst_ready = 1'b1; lat = 4;
        wait_rd("t3_rd2_seen");
        check("t3_rd2_addr", mem_addr, 2);
        step();
        redirect = 1'b1; redirect_pc = 16'h000C;
        step();
        redirect = 1'b0;
        wait_rd("t3_rd1_seen");
        check("t3_rd1_addr", mem_addr, 1);
        wait_valid("t3_valid_seen");
        check("t3_pc", inst_pc, 16'h000C);
        check("t3_inst", inst, mem[1][63:32]);
        step();
        inst_ready = 1'b0; lat = 2;
        wait_valid("t4_stall_seen");
        step();
        redirect = 1'b1; redirect_pc = 16'h000E;
        @(negedge clk);
        check("t4_fault_n", fault, 0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("t4_fault_n1", fault, 1);
        check("t4_rd_n1", mem_rd, 1);
        check("t4_addr_n1", mem_addr, 1);
        @(negedge clk);
        check("t4_fault_n2", fault, 0);
        check("t4_valid_n2", inst_valid, 0);
        @(negedge clk);
        check("t4_valid_n3", inst_valid, 0);
        @(negedge clk);
        check("t4_valid_n4", inst_valid, 1);
        check("t4_pc_n4", inst_pc, 16'h000C);
        step();
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFF8;
        step();
        redirect = 1'b0;
        wait_rd("t5_rd_top_seen");
        check("t5_rd_top_addr", mem_addr, 13'h1FFF);
        wait_rd("t5_rd_wrap_seen");
        check("t5_rd_wrap_addr", mem_addr, 0);
        wait_hs_pc("t5_wrap_pc0", 16'h0000);
`else
        wait_valid("t6_valid_seen");
        check("t6_inst0", inst, 32'h11111111);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t6_continuous", inst_valid, 1);
        end
`endif
        step();
        lat = 4;
        wait_rd("t7_rd_seen");
        step();
        reset_n = 1'b0; enable = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t7_no_valid", inst_valid, 0);
            check("t7_no_rd", mem_rd, 0);
        end
        rand_lat = 1'b1;
        h0 = hs_count;
        for (int i = 0; i < 3000; i++) begin
            step();
            enable      = $urandom_range(0, 7) != 0;
            inst_ready  = $urandom_range(0, 3) != 0;
            redirect    = $urandom_range(0, 29) == 0;
            redirect_pc = 16'($urandom);
        end
        step();
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        check("rand_progress", 64'(hs_count - h0 > 300), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end
endmodule
